// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder: mode encodings and
// helpers that derive and validate the stage count.
package adder_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int stages(input int width, input int chunk);
    return width / chunk;
  endfunction

  function automatic bit width_ok(input int width, input int chunk);
    return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/adder_pipe_stage.sv
// One carry-propagating slice: adds a CHUNK-bit pair plus carry-in and
// registers the result chunk, carry, mode and valid when the pipe advances.
module adder_pipe_stage
  import adder_pkg::*;
#(
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  input  logic             valid_in,
  input  logic             mode_in,
  input  logic             carry_in,
  input  logic [CHUNK-1:0] a_in,
  input  logic [CHUNK-1:0] b_in,
  output logic             valid_q,
  output logic             mode_q,
  output logic             carry_q,
  output logic [CHUNK-1:0] sum_q
);

  logic [CHUNK:0]   add_full;
  logic             valid_d;
  logic             mode_d;
  logic             carry_d;
  logic [CHUNK-1:0] sum_d;

  always_comb begin
    add_full = {1'b0, a_in} + {1'b0, b_in} + {{CHUNK{1'b0}}, carry_in};
    valid_d  = valid_q;
    mode_d   = mode_q;
    carry_d  = carry_q;
    sum_d    = sum_q;
    if (advance) begin
      valid_d = valid_in;
      mode_d  = mode_in;
      carry_d = add_full[CHUNK];
      sum_d   = add_full[CHUNK-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      mode_q  <= MODE_ADD;
      carry_q <= 1'b0;
      sum_q   <= '0;
    end else begin
      valid_q <= valid_d;
      mode_q  <= mode_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
    end
  end

endmodule

// File: rtl/adder_pipe.sv
// Pipelined WIDTH-bit add/subtract, one CHUNK per stage, with operand skew,
// result deskew and a global stall driven by the output handshake.
module adder_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum
);

  localparam int STAGES = stages(WIDTH, CHUNK);

  if (!width_ok(WIDTH, CHUNK)) begin : g_bad_params
    $error("adder_pipe: WIDTH must be a non-zero multiple of CHUNK");
  end

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic [STAGES:0]  valid_chain;
  logic [STAGES:0]  mode_chain;
  logic [STAGES:0]  carry_chain;
  logic [CHUNK-1:0] a_at_stage  [STAGES];
  logic [CHUNK-1:0] b_at_stage  [STAGES];
  logic [CHUNK-1:0] stg_sum     [STAGES];
  logic [CHUNK-1:0] res_aligned [STAGES];
  logic [WIDTH-1:0] res_flat;
  logic             out_valid_d, out_valid_q;
  logic [WIDTH:0]   sum_d, sum_q;

  assign advance = !out_valid_q || out_ready;
  assign in_ready  = advance;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;

  // Subtraction is a + ~b + 1: invert B up front, the +1 enters as stage 0 carry-in.
  assign b_eff          = (sub == MODE_SUB) ? ~b : b;
  assign valid_chain[0] = in_valid;
  assign mode_chain[0]  = sub;
  assign carry_chain[0] = sub;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int SKEW   = gi;
    localparam int DESKEW = STAGES - 1 - gi;

    if (SKEW == 0) begin : g_no_skew
      assign a_at_stage[gi] = a[gi*CHUNK +: CHUNK];
      assign b_at_stage[gi] = b_eff[gi*CHUNK +: CHUNK];
    end else begin : g_skew
      logic [CHUNK-1:0] a_skew_q [SKEW];
      logic [CHUNK-1:0] a_skew_d [SKEW];
      logic [CHUNK-1:0] b_skew_q [SKEW];
      logic [CHUNK-1:0] b_skew_d [SKEW];

      always_comb begin
        a_skew_d = a_skew_q;
        b_skew_d = b_skew_q;
        if (advance) begin
          a_skew_d[0] = a[gi*CHUNK +: CHUNK];
          b_skew_d[0] = b_eff[gi*CHUNK +: CHUNK];
          for (int j = 1; j < SKEW; j++) begin
            a_skew_d[j] = a_skew_q[j-1];
            b_skew_d[j] = b_skew_q[j-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int j = 0; j < SKEW; j++) begin
            a_skew_q[j] <= '0;
            b_skew_q[j] <= '0;
          end
        end else begin
          a_skew_q <= a_skew_d;
          b_skew_q <= b_skew_d;
        end
      end

      assign a_at_stage[gi] = a_skew_q[SKEW-1];
      assign b_at_stage[gi] = b_skew_q[SKEW-1];
    end

    adder_pipe_stage #(.CHUNK(CHUNK)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .advance  (advance),
      .valid_in (valid_chain[gi]),
      .mode_in  (mode_chain[gi]),
      .carry_in (carry_chain[gi]),
      .a_in     (a_at_stage[gi]),
      .b_in     (b_at_stage[gi]),
      .valid_q  (valid_chain[gi+1]),
      .mode_q   (mode_chain[gi+1]),
      .carry_q  (carry_chain[gi+1]),
      .sum_q    (stg_sum[gi])
    );

    if (DESKEW == 0) begin : g_no_deskew
      assign res_aligned[gi] = stg_sum[gi];
    end else begin : g_deskew
      logic [CHUNK-1:0] dsk_q [DESKEW];
      logic [CHUNK-1:0] dsk_d [DESKEW];

      always_comb begin
        dsk_d = dsk_q;
        if (advance) begin
          dsk_d[0] = stg_sum[gi];
          for (int j = 1; j < DESKEW; j++) begin
            dsk_d[j] = dsk_q[j-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int j = 0; j < DESKEW; j++) begin
            dsk_q[j] <= '0;
          end
        end else begin
          dsk_q <= dsk_d;
        end
      end

      assign res_aligned[gi] = dsk_q[DESKEW-1];
    end
  end

  // Top bit is carry for add and inverted carry (borrow) for sub.
  always_comb begin
    res_flat = '0;
    for (int k = 0; k < STAGES; k++) begin
      res_flat[k*CHUNK +: CHUNK] = res_aligned[k];
    end
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    if (advance) begin
      out_valid_d = valid_chain[STAGES];
      sum_d       = {carry_chain[STAGES] ^ mode_chain[STAGES], res_flat};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
    end
  end

endmodule

// File: tb/tb_adder_pipe.sv
// Directed bench for adder_pipe: scoreboard of expected sums, latency,
// backpressure, mid-flight reset and a narrower 32/8 instance.
module tb_adder_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, sub, out_valid, out_ready;
  logic [63:0] a, b;
  logic [64:0] sum;

  logic        in_valid2, in_ready2, sub2, out_valid2, out_ready2;
  logic [31:0] a2, b2;
  logic [32:0] sum2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stale = 0;
  bit check_lat = 1'b0;
  logic [64:0] exp_q[$];
  int          lat_q[$];

  always #5 clk = ~clk;

  adder_pipe #(.WIDTH(64), .CHUNK(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum)
  );

  adder_pipe #(.WIDTH(32), .CHUNK(8)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .sub(sub2), .out_valid(out_valid2), .out_ready(out_ready2),
    .sum(sum2)
  );

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [64:0] model(input logic [63:0] x, input logic [63:0] y,
                                        input logic m);
    if (m) return {(x < y), x - y};
    return {1'b0, x} + {1'b0, y};
  endfunction

  // One clock: check output transfer / record accept at negedge, then advance.
  task automatic step(output bit accepted);
    logic [64:0] e;
    int          t;
    accepted = 1'b0;
    @(negedge clk);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        stale++;
        chk("unexpected_out", {64'd0, out_valid}, 65'd0);
      end else begin
        e = exp_q.pop_front();
        t = lat_q.pop_front();
        $display("out cyc=%0d sum=%h exp=%h", cyc, sum, e);
        chk("sum", sum, e);
        if (check_lat) chk("latency", 65'(cyc - t), 65'd4);
      end
    end
    if (in_valid && in_ready && !rst) begin
      exp_q.push_back(model(a, b, sub));
      lat_q.push_back(cyc + 1);
      accepted = 1'b1;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic tick();
    bit acc;
    step(acc);
  endtask

  task automatic send(input logic [63:0] x, input logic [63:0] y, input logic m,
                      output int n);
    bit acc;
    a = x; b = y; sub = m; in_valid = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      step(acc);
      n++;
    end
    if (!acc) chk("send_timeout", 65'(n), 65'd0);
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    chk("drain_empty", 65'(exp_q.size()), 65'd0);
  endtask

  initial begin
    int          n;
    logic [64:0] held;
    logic [63:0] ra, rb;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
    in_valid2 = 1'b0; a2 = '0; b2 = '0; sub2 = 1'b0; out_ready2 = 1'b1;
    tick(); tick();
    chk("reset_out_valid", {64'd0, out_valid}, 65'd0);
    chk("reset_sum", sum, 65'd0);
    chk("reset_in_ready", {64'd0, in_ready}, 65'd1);
    rst = 1'b0;

    // Single adds with latency check
    check_lat = 1'b1;
    send(64'd18446744073709551614, 64'd1, 1'b0, n);
    drain();
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, n);
    drain();

    // Back-to-back stream
    send(64'd184, 64'd1256, 1'b0, n);
    send(64'd14, 64'd7, 1'b0, n);
    send(64'd156596564, 64'd125556, 1'b0, n);
    drain();

    // Subtraction, then a mixed-mode stream
    send(64'd14, 64'd7, 1'b1, n);
    send(64'd7, 64'd14, 1'b1, n);
    drain();
    for (int i = 0; i < 8; i++) begin
      ra = {$urandom(), $urandom()};
      rb = (i % 3 == 0) ? ra + 64'd5 : {$urandom(), $urandom()};
      send(ra, rb, i[0], n);
    end
    drain();

    // Backpressure: fill, stall 5 cycles, release
    check_lat = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(64'd1000 + 64'(i), 64'd3, i[0], n);
    a = 64'd77; b = 64'd88; sub = 1'b0; in_valid = 1'b1;
    held = sum;
    chk("stall_full_out_valid", {64'd0, out_valid}, 65'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_in_ready", {64'd0, in_ready}, 65'd0);
      chk("stall_out_valid", {64'd0, out_valid}, 65'd1);
      chk("stall_sum", sum, held);
    end
    out_ready = 1'b1;
    send(64'd77, 64'd88, 1'b0, n);
    chk("simul_accept_steps", 65'(n), 65'd1);
    drain();

    // Reset with three beats in flight
    send(64'd1, 64'd2, 1'b0, n);
    send(64'd3, 64'd4, 1'b1, n);
    send(64'd5, 64'd6, 1'b0, n);
    in_valid = 1'b0;
    exp_q.delete();
    lat_q.delete();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_out_valid", {64'd0, out_valid}, 65'd0);
    chk("midrst_sum", sum, 65'd0);
    for (int i = 0; i < 10; i++) tick();
    chk("no_stale_results", 65'(stale), 65'd0);

    // Narrow instance: one add with full carry ripple
    a2 = 32'hFFFF_FFFF; b2 = 32'd1; sub2 = 1'b0; in_valid2 = 1'b1;
    chk("w32_in_ready", {64'd0, in_ready2}, 65'd1);
    tick();
    in_valid2 = 1'b0;
    n = 0;
    while (!out_valid2 && n < 20) begin
      tick();
      n++;
    end
    $display("out32 sum=%h after %0d cycles", sum2, n);
    chk("w32_latency", 65'(n), 65'd4);
    chk("w32_sum", {32'd0, sum2}, 65'h1_0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_pipe.md
# adder_pipe

Parametrised, pipelined successor to the team's 64-bit combinational adder. Adds or subtracts two WIDTH-bit unsigned operands in CHUNK-bit carry-propagating stages, one chunk per clock, with valid/ready handshakes on both sides. It sits between the operand register file and the result writeback path wherever a full-width ripple add would miss timing.

## Interface
- WIDTH, 64: operand width in bits; must be a multiple of CHUNK.
- CHUNK, 16: bits added per pipeline stage; STAGES = WIDTH/CHUNK, and STAGES ≥ 1.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous and active-high.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  WIDTH  operand A, unsigned.
- b  in  WIDTH  operand B, unsigned.
- sub  in  1  mode: 0 computes a+b, 1 computes a−b.
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH+1  result; bit WIDTH is carry (add) or borrow (sub).

## Operation
- Accept on in_valid && in_ready. Output transfer on out_valid && out_ready.
- Add: sum = a + b, with the full WIDTH+1-bit result.
- Sub: internally computes a + ~b + 1. sum[WIDTH−1:0] = (a − b) mod 2^WIDTH. sum[WIDTH] = 1 iff a < b (borrow, i.e. inverted carry-out).
- Stage k (0..STAGES−1) adds chunk k of both operands plus the registered carry from stage k−1. Stage 0 carry-in = sub.
- Skew: chunk k of the operands is delayed k cycles before stage k.
- Deskew: the result chunk from stage k is delayed STAGES−1−k cycles, so all chunks leave together.
- The mode bit and a per-stage valid bit travel with the data.
- Global stall: advance = !out_valid || out_ready. in_ready = advance.
- When advance = 0, every pipeline register, skew register and valid bit holds.
- When advance = 1, valid bits shift. A stage with a 0 valid holds a bubble. Data in bubble stages is don't-care, but its valid bit must be 0.
- No combinational path from in_valid to out_valid. in_ready depends only on out_valid and out_ready.

## Timing
- Latency: a beat accepted at edge t (with no stall) gives out_valid=1 and a valid sum after edge t+STAGES.
- Throughput: one beat per cycle when out_ready is held at 1.
- Each stall cycle adds one cycle of latency to every beat in flight. Beat order is always preserved.
- Reset values: out_valid=0, all internal valid bits 0, sum=0, carries 0. in_ready=1 in the cycle after reset.
- Reset mid-operation: all in-flight beats are discarded. No partial result is ever presented.
- Simultaneous output transfer and input accept in a stalled-full pipeline: both happen in the same cycle. There is no bubble insertion.
- STAGES=1: the block degenerates to a registered single-cycle adder with the same handshake.

## Structure
- Package adder_pkg:
  - MODE_ADD=1'b0 and MODE_SUB=1'b1.
  - function stages(width, chunk) returning width/chunk.
  - Elaboration check that WIDTH % CHUNK == 0.
- Sub-module adder_pipe_stage, instantiated STAGES times:
  - CHUNK-bit adder with carry in and carry out.
  - Registered result chunk, carry out and valid bit, gated by advance.
- Skew and deskew delay lines are generated shift registers in the top level.

## Test plan
- WIDTH=64, CHUNK=16, add: a=18446744073709551614, b=1 → sum=18446744073709551615, sum[64]=0, out_valid exactly 4 cycles after accept.
- Full carry ripple: a=0xFFFF_FFFF_FFFF_FFFF, b=1, add → sum=65'h1_0000_0000_0000_0000. Carry must cross all 4 stages.
- Back-to-back stream with out_ready=1: (184,1256), (14,7), (156596564,125556) → results 1440, 21, 156722120 on consecutive cycles, in order.
- Sub:
  - 14−7 → sum=7, borrow=0.
  - 7−14 → sum[63:0]=0xFFFF_FFFF_FFFF_FFF9, sum[64]=1.
  - Mixed add/sub beats in one stream keep their modes.
- Backpressure: fill the pipeline, hold out_ready=0 for 5 cycles.
  - Required: in_ready=0 throughout, sum and out_valid stable.
  - On release, no beat lost or duplicated.
- rst asserted with 3 beats in flight → out_valid=0 the next cycle, no stale result appears afterwards. Also repeat one add with WIDTH=32, CHUNK=8.
